// File: rtl/shift_pkg.sv
// Shared op encodings and geometry helpers for the pipelined barrel shifter.
package shift_pkg;

    localparam int unsigned OP_W = 2;

    typedef logic [OP_W-1:0] shift_op_t;

    localparam shift_op_t SHIFT_SLL = 2'b00;
    localparam shift_op_t SHIFT_SRL = 2'b01;
    localparam shift_op_t SHIFT_SRA = 2'b10;
    localparam shift_op_t SHIFT_ROR = 2'b11;

    // Number of shift layers (distances 1, 2, 4, ...) for an operand width.
    function automatic int unsigned calc_layers(input int unsigned width);
        return $clog2(width);
    endfunction

    // Number of pipeline stages when layers are grouped lps at a time.
    function automatic int unsigned calc_stages(input int unsigned width, input int unsigned lps);
        return (calc_layers(width) + lps - 1) / lps;
    endfunction

endpackage

// File: rtl/shift_layer.sv
// One combinational shift layer: shifts by DIST when enabled, fill chosen by op.
module shift_layer
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             enable,
    input  shift_op_t        op,
    input  logic             sign,
    output logic [WIDTH-1:0] data_out
);

    always_comb begin
        data_out = data;
        if (enable) begin
            case (op)
                SHIFT_SLL: data_out = data << DIST;
                SHIFT_SRL: data_out = data >> DIST;
                SHIFT_SRA: data_out = {{DIST{sign}}, data[WIDTH-1:DIST]};
                SHIFT_ROR: data_out = {data[DIST-1:0], data[WIDTH-1:DIST]};
                default:   data_out = data;
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Elastic pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready on both sides.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH            = 64,
    parameter int unsigned LAYERS_PER_STAGE = 2,
    parameter int unsigned TAG_W            = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_shamt,
    input  shift_op_t        in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_neg,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned L = calc_layers(WIDTH);
    localparam int unsigned S = calc_stages(WIDTH, LAYERS_PER_STAGE);

    logic [S-1:0]     st_valid;
    logic [WIDTH-1:0] st_data  [S];
    logic [L-1:0]     st_shamt [S];
    shift_op_t        st_op    [S];
    logic             st_sign  [S];
    logic [TAG_W-1:0] st_tag   [S];
    logic             st_zero;
    logic             st_neg;

    logic [S-1:0]     src_valid;
    logic [WIDTH-1:0] src_data  [S];
    logic [L-1:0]     src_shamt [S];
    shift_op_t        src_op    [S];
    logic             src_sign  [S];
    logic [TAG_W-1:0] src_tag   [S];

    logic [WIDTH-1:0] lay_in     [L];
    logic [WIDTH-1:0] lay_out    [L];
    logic [WIDTH-1:0] stage_next [S];
    logic [S-1:0]     take;

    // Shamt bits above L-1 are ignored; the last stage's control fields have no consumer.
    logic unused_shamt_hi;
    logic unused_tail;
    assign unused_shamt_hi = ^in_shamt[WIDTH-1:L];
    assign unused_tail     = ^{st_shamt[S-1], st_op[S-1], st_sign[S-1]};

    // Stage k feeds from the input port (k = 0) or from the previous stage register.
    always_comb begin
        src_valid    = '0;
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        src_shamt[0] = in_shamt[L-1:0];
        src_op[0]    = in_op;
        src_sign[0]  = in_data[WIDTH-1];
        src_tag[0]   = in_tag;
        for (int k = 1; k < S; k++) begin
            src_valid[k] = st_valid[k-1];
            src_data[k]  = st_data[k-1];
            src_shamt[k] = st_shamt[k-1];
            src_op[k]    = st_op[k-1];
            src_sign[k]  = st_sign[k-1];
            src_tag[k]   = st_tag[k-1];
        end
    end

    // A slot can load if it, or any slot downstream of it, is empty, or the consumer takes the head.
    always_comb begin
        take = '0;
        for (int k = 0; k < S; k++) begin
            take[k] = out_ready;
            for (int j = k; j < S; j++) begin
                if (!st_valid[j]) begin
                    take[k] = 1'b1;
                end
            end
        end
    end

    assign in_ready = take[0];

    for (genvar i = 0; i < L; i++) begin : g_layer
        localparam int unsigned K = i / LAYERS_PER_STAGE;
        if (i % LAYERS_PER_STAGE == 0) begin : g_head
            assign lay_in[i] = src_data[K];
        end else begin : g_chain
            assign lay_in[i] = lay_out[i-1];
        end
        shift_layer #(
            .WIDTH (WIDTH),
            .DIST  (1 << i)
        ) u_layer (
            .data     (lay_in[i]),
            .enable   (src_shamt[K][i]),
            .op       (src_op[K]),
            .sign     (src_sign[K]),
            .data_out (lay_out[i])
        );
    end

    for (genvar k = 0; k < S; k++) begin : g_stage
        localparam int unsigned END_IDX = ((k + 1) * LAYERS_PER_STAGE < L) ?
                                          (k + 1) * LAYERS_PER_STAGE : L;
        assign stage_next[k] = lay_out[END_IDX-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_valid <= '0;
            st_zero  <= 1'b0;
            st_neg   <= 1'b0;
            for (int k = 0; k < S; k++) begin
                st_data[k]  <= '0;
                st_shamt[k] <= '0;
                st_op[k]    <= SHIFT_SLL;
                st_sign[k]  <= 1'b0;
                st_tag[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < S; k++) begin
                if (take[k]) begin
                    st_valid[k] <= src_valid[k];
                    if (src_valid[k]) begin
                        st_data[k]  <= stage_next[k];
                        st_shamt[k] <= src_shamt[k];
                        st_op[k]    <= src_op[k];
                        st_sign[k]  <= src_sign[k];
                        st_tag[k]   <= src_tag[k];
                    end
                end
            end
            // Flags are registered alongside the final data so they hold through a stall.
            if (take[S-1] && src_valid[S-1]) begin
                st_zero <= (stage_next[S-1] == '0);
                st_neg  <= stage_next[S-1][WIDTH-1];
            end
        end
    end

    assign out_valid = st_valid[S-1];
    assign out_data  = st_data[S-1];
    assign out_tag   = st_tag[S-1];
    assign out_zero  = st_zero;
    assign out_neg   = st_neg;

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: queue-based reference model plus directed and swept vectors.
module tb_shift_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_zero, out_neg;
    logic [63:0] in_data, in_shamt, out_data;
    logic [1:0]  in_op;
    logic [3:0]  in_tag, out_tag;

    logic [2:0]   sw_valid, sw_in_ready, sw_out_valid, sw_zero, sw_neg;
    logic [127:0] sw_data, sw_shamt;
    logic [1:0]   sw_op;
    logic [3:0]   sw_tag;
    logic [3:0]   sw_otag [3];
    logic [7:0]   o8;
    logic [31:0]  o32;
    logic [127:0] o128;
    logic [127:0] sw_od [3];

    assign sw_od[0] = {120'b0, o8};
    assign sw_od[1] = {96'b0, o32};
    assign sw_od[2] = o128;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  tag;
        int          acc;
    } exp_t;

    exp_t       q[$];
    logic [3:0] tag_log[$];
    exp_t       e;
    int         n_chk = 0, n_pass = 0, n_fail = 0;
    int         cyc = 0;
    int         last_lat = 0;
    bit         seen = 0;
    bit         saw_block = 0;
    logic [63:0] last_data = '0;
    logic        last_zero = 0, last_neg = 0;
    logic [3:0]  tag_ctr = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_pipe #(.WIDTH(64), .LAYERS_PER_STAGE(2), .TAG_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_neg(out_neg), .out_tag(out_tag));

    shift_pipe #(.WIDTH(8), .LAYERS_PER_STAGE(1), .TAG_W(4)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid[0]), .in_ready(sw_in_ready[0]),
        .in_data(sw_data[7:0]), .in_shamt(sw_shamt[7:0]), .in_op(sw_op), .in_tag(sw_tag),
        .out_valid(sw_out_valid[0]), .out_ready(1'b1), .out_data(o8),
        .out_zero(sw_zero[0]), .out_neg(sw_neg[0]), .out_tag(sw_otag[0]));

    shift_pipe #(.WIDTH(32), .LAYERS_PER_STAGE(5), .TAG_W(4)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid[1]), .in_ready(sw_in_ready[1]),
        .in_data(sw_data[31:0]), .in_shamt(sw_shamt[31:0]), .in_op(sw_op), .in_tag(sw_tag),
        .out_valid(sw_out_valid[1]), .out_ready(1'b1), .out_data(o32),
        .out_zero(sw_zero[1]), .out_neg(sw_neg[1]), .out_tag(sw_otag[1]));

    shift_pipe #(.WIDTH(128), .LAYERS_PER_STAGE(1), .TAG_W(4)) u_w128 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid[2]), .in_ready(sw_in_ready[2]),
        .in_data(sw_data), .in_shamt(sw_shamt), .in_op(sw_op), .in_tag(sw_tag),
        .out_valid(sw_out_valid[2]), .out_ready(1'b1), .out_data(o128),
        .out_zero(sw_zero[2]), .out_neg(sw_neg[2]), .out_tag(sw_otag[2]));

    // Bit-by-bit definition of each op: result bit b is drawn from source bit b -/+ amt.
    function automatic logic [127:0] ref_shift(int unsigned w, logic [127:0] d,
                                               logic [127:0] sh, logic [1:0] op);
        logic [127:0] r;
        int unsigned  amt;
        r   = '0;
        amt = 32'(sh % 128'(w));
        for (int unsigned b = 0; b < w; b++) begin
            case (op)
                2'b00:   r[b] = (b >= amt) ? d[b-amt] : 1'b0;
                2'b01:   r[b] = (b + amt < w) ? d[b+amt] : 1'b0;
                2'b10:   r[b] = (b + amt < w) ? d[b+amt] : d[w-1];
                default: r[b] = d[(b+amt)%w];
            endcase
        end
        return r;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Compare process: every visible result is checked against the head of the model queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 128'(out_valid), 128'(0));
                end else begin
                    e = q[0];
                    chk("out_data", 128'(out_data), 128'(e.data));
                    chk("out_tag", 128'(out_tag), 128'(e.tag));
                    chk("out_zero", 128'(out_zero), 128'(e.data == 64'd0));
                    chk("out_neg", 128'(out_neg), 128'(e.data[63]));
                    if (!seen) begin
                        last_lat = cyc - e.acc;
                        seen     = 1'b1;
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        seen      = 1'b0;
                        last_data = out_data;
                        last_zero = out_zero;
                        last_neg  = out_neg;
                        tag_log.push_back(out_tag);
                    end
                end
            end
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (in_valid && in_ready) begin
                e.data = ref_shift(64, 128'(in_data), 128'(in_shamt), in_op)[63:0];
                e.tag  = in_tag;
                e.acc  = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic send(logic [63:0] d, logic [63:0] sh, logic [1:0] op, logic [3:0] tag);
        bit acc;
        int n;
        in_valid = 1'b1; in_data = d; in_shamt = sh; in_op = op; in_tag = tag;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) chk("send_timeout", 128'(acc), 128'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_done", 128'(q.size()), 128'(0));
    endtask

    task automatic dir(logic [63:0] d, logic [63:0] sh, logic [1:0] op,
                       logic [63:0] exp_d, logic ez, logic en);
        send(d, sh, op, tag_ctr);
        tag_ctr = tag_ctr + 4'd1;
        drain();
        chk("dir_data", 128'(last_data), 128'(exp_d));
        chk("dir_zero", 128'(last_zero), 128'(ez));
        chk("dir_neg", 128'(last_neg), 128'(en));
        chk("dir_latency", 128'(last_lat), 128'(3));
    endtask

    task automatic sweep(int idx, int unsigned w, int unsigned s);
        logic [127:0] expv, mask;
        int lat;
        mask = (w == 128) ? '1 : ((128'(1) << w) - 128'(1));
        for (int n = 0; n < 16; n++) begin
            sw_data  = {$urandom, $urandom, $urandom, $urandom};
            sw_shamt = 128'($urandom_range(0, 2 * w + 5));
            sw_op    = 2'($urandom_range(0, 3));
            sw_tag   = 4'(n);
            expv     = ref_shift(w, sw_data & mask, sw_shamt, sw_op);
            sw_valid[idx] = 1'b1;
            @(negedge clk);
            chk("sw_in_ready", 128'(sw_in_ready[idx]), 128'(1));
            @(posedge clk); #1;
            sw_valid[idx] = 1'b0;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!sw_out_valid[idx] && lat < 40);
            chk("sw_latency", 128'(lat), 128'(s));
            chk("sw_data", sw_od[idx], expv);
            chk("sw_tag", 128'(sw_otag[idx]), 128'(n));
            chk("sw_zero", 128'(sw_zero[idx]), 128'(expv == 128'd0));
            chk("sw_neg", 128'(sw_neg[idx]), 128'(expv[w-1]));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_shamt = '0; in_op = 2'b00; in_tag = '0;
        sw_valid = '0; sw_data = '0; sw_shamt = '0; sw_op = 2'b00; sw_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        chk("rst_out_zero", 128'(out_zero), 128'(0));
        chk("rst_out_neg", 128'(out_neg), 128'(0));
        chk("rst_out_tag", 128'(out_tag), 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 128'(in_ready), 128'(1));

        dir(64'h8000_0000_0000_0000, 64'd63, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        dir(64'h8000_0000_0000_0000, 64'd64, 2'b01, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        dir(64'h1, 64'd65, 2'b00, 64'h2, 1'b0, 1'b0);
        dir(64'hF1, 64'd4, 2'b11, 64'h1000_0000_0000_000F, 1'b0, 1'b0);
        dir(64'h1, 64'd63, 2'b00, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        dir(64'h1, 64'd1, 2'b01, 64'h0, 1'b1, 1'b0);
        dir(64'h0123_4567_89AB_CDEF, 64'd0, 2'b11, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);

        // Eight back-to-back requests with a five-cycle consumer stall in the middle.
        tag_log.delete();
        saw_block = 1'b0;
        fork
            begin
                for (int t = 0; t < 8; t++)
                    send({$urandom, $urandom}, 64'($urandom_range(0, 200)), 2'(t % 4), 4'(t));
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_in_ready_dropped", 128'(saw_block), 128'(1));
        chk("stall_count", 128'(tag_log.size()), 128'(8));
        for (int t = 0; t < 8; t++) begin
            if (t < tag_log.size()) chk("stall_tag_order", 128'(tag_log[t]), 128'(t));
        end

        // Reset with three operations in flight.
        for (int t = 0; t < 3; t++) send(64'hA5A5_0000_0000_0001 + 64'(t), 64'(t + 1), 2'b00, 4'(t));
        #1 rst_n = 1'b0;
        #1 chk("midrst_out_valid", 128'(out_valid), 128'(0));
        q.delete();
        seen = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_idle", 128'(out_valid), 128'(0));
        dir(64'h0000_0000_0000_00F0, 64'd4, 2'b01, 64'hF, 1'b0, 1'b0);

        sweep(0, 8, 3);
        sweep(1, 32, 1);
        sweep(2, 128, 7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, pipelined barrel shifter for the ALU datapath. It is the successor to the single-cycle 64-bit arithmetic-right-shift unit. It supports logical left, logical right, arithmetic right and rotate right on a WIDTH-bit operand. Pipeline registers sit between groups of shift layers, with a valid/ready handshake on both sides so the execute stage can stall it.

## Interface
- WIDTH, 64: operand width; power of two, 8..128.
- LAYERS_PER_STAGE, 2: shift layers (distances 1, 2, 4, …) evaluated combinationally between pipeline registers; 1..log2(WIDTH).
- TAG_W, 4: width of the sideband tag carried alongside each operation.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block accepts the request this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  WIDTH  shift amount; only bits [log2(WIDTH)-1:0] are used.
- in_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result this cycle.
- out_data  out  WIDTH  shifted result.
- out_zero  out  1  out_data == 0.
- out_neg  out  1  out_data[WIDTH-1].
- out_tag  out  TAG_W  tag of this result.

## Operation
- L = log2(WIDTH) layers; layer i shifts by 2^i when shamt bit i is set.
- Layers are grouped LAYERS_PER_STAGE at a time. Stage count S = ceil(L / LAYERS_PER_STAGE). Each stage ends in a register holding valid, data, remaining shamt bits, op and tag.
- SLL: zero fill from the LSB side.
- SRL: zero fill from the MSB side.
- SRA: fill with the original operand's MSB. The sign is latched at input and carried down the pipe; it is not re-read from intermediate data.
- ROR: bits shifted out at the LSB re-enter at the MSB.
- Shamt bits above L-1 are ignored, so a shamt of WIDTH+3 behaves as 3 for every op. Shamt 0 returns the operand unchanged.
- out_zero and out_neg are computed from the final stage's data. They are meaningful only while out_valid = 1.
- Elastic pipeline: stage k advances when its downstream slot is empty or is advancing itself. out_ready = 0 with the final stage full freezes every full stage upstream of it; bubbles still collapse.
- in_ready = !stage0_valid || stage0_advancing, combinational from out_ready through the stall chain.
- Order is preserved: results leave in acceptance order, so tags are never reordered.

## Timing
- Latency: S cycles from the accept edge (in_valid & in_ready) to out_valid. Default WIDTH 64, LAYERS_PER_STAGE 2 gives S = 3.
- Throughput: one result per cycle while out_ready = 1.
- While out_valid = 1 and out_ready = 0, out_data, out_tag, out_zero and out_neg hold stable until the handshake completes.
- Reset (asynchronous assert) clears all stage valids. Outputs go to: out_valid 0, out_data 0, out_zero 0, out_neg 0, out_tag 0. in_ready is 1 once rst_n is deasserted.
- Reset asserted mid-stream discards all in-flight operations. No result is emitted for them after release.
- Simultaneous accept and emit on the same cycle with a full pipe is legal and keeps the pipe full with no bubble.
- LAYERS_PER_STAGE = L gives S = 1: a single registered stage with the same handshake rules.

## Structure
- Package shift_pkg holds:
  - op encodings SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROR as localparams;
  - the 2-bit op typedef;
  - the CLOG2-based helper constants for L and S.
- Sub-module shift_layer: one combinational layer parametrised by WIDTH and DIST. It has inputs data, enable, op and sign, and output data. shift_pipe instantiates L of these in a generate loop.
- Stage registers and handshake logic live in shift_pipe. There is no separate FIFO.

## Test plan
- WIDTH 64, SRA, data 0x8000_0000_0000_0000, shamt 63 -> out_data 0xFFFF_FFFF_FFFF_FFFF, out_neg 1, out_zero 0, out_valid exactly 3 cycles after accept.
- SRL, data 0x8000_0000_0000_0000, shamt 64 -> out_data unchanged (shamt masked to 0). SLL, data 1, shamt 65 -> 0x2.
- ROR, data 0x0000_0000_0000_00F1, shamt 4 -> 0x1000_0000_0000_000F. SLL, data 1, shamt 63 -> 0x8000…0 with out_neg 1. SRL, data 1, shamt 1 -> out_zero 1.
- Back-to-back 8 requests with tags 0..7, out_ready held 0 for 5 cycles mid-stream:
  - in_ready drops once the pipe fills;
  - outputs stay stable while stalled;
  - all 8 results emerge in tag order with none lost or duplicated.
- Assert rst_n low for 1 cycle with 3 operations in flight -> out_valid 0 immediately, no stale result after release, first new request completes normally.
- Parameter sweep over WIDTH ∈ {8, 32, 128} and LAYERS_PER_STAGE ∈ {1, L}: random data/shamt/op checked against a reference model; measured latency equals S.
